operand_fwd_mux: RTL and testbench
==================================

# operand_fwd_mux

Parametrised operand-forwarding selector with an output pipeline register. It is the successor to the fixed 2/3-input select muxes. For one source operand it picks the newest in-flight value from NSRC producing pipeline stages, or the register-file value when no stage matches, and flags a hazard when the matching producer has no data yet. It captures the result into a stall/flush-controlled stage register and keeps a saturating count of forwarded operands. One instance sits per operand (rs, rt) at the D→E boundary.

## Interface
- DW, 32, operand data width
- AW, 5, register index width
- NSRC, 3, number of producing stages; stage 0 is the youngest and has highest priority
- SELW (localparam) = $clog2(NSRC+1), select-code width

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold the output register
- flush  in  1  insert a bubble into the output register
- in_valid  in  1  operand request is valid this cycle
- src_addr  in  AW  source register index
- rf_data  in  DW  register-file read data
- fwd_addr  in  NSRC*AW  destination index of stage k at [k*AW +: AW]
- fwd_we  in  NSRC  stage k will write a register
- fwd_rdy  in  NSRC  stage k result is available now
- fwd_data  in  NSRC*DW  result of stage k at [k*DW +: DW]
- hazard  out  1  combinational; the selected producer is not ready
- out_valid  out  1  registered operand valid
- out_data  out  DW  registered operand
- out_sel  out  SELW  registered source: 0 = rf_data, k+1 = stage k
- fwd_count  out  16  saturating count of captured forwarded operands

## Operation
- Stage k matches when fwd_we[k] is high, fwd_addr[k] == src_addr, and src_addr != 0. Index 0 never forwards.
- Selection uses the lowest matching k. With no match, the source is rf_data and the select code is 0. With a match, the source is fwd_data[k] and the select code is k+1.
- hazard = in_valid && a match exists && !fwd_rdy[k_sel].
  - Only the highest-priority match counts.
  - An older, ready match never masks a younger, unready one.
- hazard is independent of stall and flush. The pipeline controller ORs it into the upstream stall.
- Register update priority, checked each rising edge: reset > flush > stall > capture.
  - reset: out_valid=0, out_data=0, out_sel=0, fwd_count=0.
  - flush: out_valid=0, out_data=0, out_sel=0. fwd_count is unchanged.
  - stall: all outputs hold. fwd_count is unchanged.
  - capture with in_valid && !hazard: out_valid=1, out_data=selected data, out_sel=select code.
  - capture otherwise (bubble): out_valid=0, out_data=0, out_sel=0.
- fwd_count increments by 1 on each capture with out_valid set and select code != 0. It saturates at 16'hFFFF and does not wrap.
- Widths: all equality compares are AW bits wide. No arithmetic on data. fwd_count is 16 bits unsigned.

## Timing
- Latency is 1 cycle: inputs sampled at edge n appear on out_* after edge n.
- hazard is a zero-latency combinational output of the current inputs.
- Reset values: out_valid=0, out_data=0, out_sel=0, fwd_count=0. hazard follows its inputs even during reset.
- Simultaneous flush and stall: flush wins.
- Simultaneous reset and anything else: reset wins.
- Reset during a held stall: all outputs clear on that edge. The stall is ignored.
- Stall release: the first non-stalled edge captures the current inputs. Inputs presented during the stall are not remembered.
- NSRC=1 is legal (SELW=1). fwd_count at FFFF stays at FFFF on further forwards.

## Test plan
- Reset: assert reset 2 cycles with random inputs → out_valid=0, out_data=0, out_sel=0, fwd_count=0.
- No match: src_addr=5, all fwd_we=0, rf_data=32'h1111, in_valid=1 → next cycle out_data=32'h1111, out_sel=0, out_valid=1, fwd_count unchanged.
- Priority:
  - Stimulus: src_addr=8; stages 0 and 2 both write r8, both ready; fwd_data0=A0, fwd_data2=C2.
  - Required: out_data=A0, out_sel=1, fwd_count increments by 1.
  - Then src_addr=0 with the same stages → out_sel=0, out_data=rf_data.
- Hazard:
  - Stimulus: stage 0 matches with fwd_rdy0=0, stage 1 matches and is ready.
  - Required: hazard=1 the same cycle, next out_valid=0.
  - Then raise fwd_rdy0 → hazard=0, next out_data=fwd_data0.
- Stall/flush:
  - Capture X, then stall=1 for 3 cycles with new inputs → out_data stays X.
  - stall=1 with flush=1 → out_valid=0, out_data=0, fwd_count unchanged.
- Saturation: force 65537 forwarded captures → fwd_count reads 16'hFFFF and stays there. Then reset → 0.

Source files
------------

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
//
// Per-operand forwarding selector for the D->E boundary. Picks the newest
// in-flight producer of src_addr among NSRC pipeline stages (stage 0 is the
// youngest and wins), falls back to the register file when nothing matches,
// and raises hazard when the chosen producer has not produced its data yet.
// The selected operand is captured into a stall/flush-controlled stage
// register, and a saturating counter tracks how many forwarded operands
// were captured.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   stall      hold the output register
//   flush      load a bubble into the output register
//   in_valid   operand request valid this cycle
//   src_addr   source register index (index 0 never forwards)
//   rf_data    register-file read data
//   fwd_addr   destination index of stage k at [k*AW +: AW]
//   fwd_we     stage k will write a register
//   fwd_rdy    stage k result is available now
//   fwd_data   result of stage k at [k*DW +: DW]
//   hazard     combinational: selected producer not ready
//   out_valid  registered operand valid
//   out_data   registered operand
//   out_sel    registered source: 0 = rf_data, k+1 = stage k
//   fwd_count  saturating count of captured forwarded operands

module operand_fwd_mux #(
   parameter  int DW   = 32,
   parameter  int AW   = 5,
   parameter  int NSRC = 3,
   localparam int SELW = $clog2(NSRC + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [AW-1:0]        src_addr,
   input  logic [DW-1:0]        rf_data,
   input  logic [NSRC*AW-1:0]   fwd_addr,
   input  logic [NSRC-1:0]      fwd_we,
   input  logic [NSRC-1:0]      fwd_rdy,
   input  logic [NSRC*DW-1:0]   fwd_data,
   output logic                 hazard,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic [SELW-1:0]      out_sel,
   output logic [15:0]          fwd_count
);

   logic [NSRC-1:0] match;
   logic            any_match;
   logic [SELW-1:0] sel_code;
   logic [DW-1:0]   sel_data;
   logic            sel_rdy;
   logic            capture;

   always_comb begin
      match = '0;
      for (int k = 0; k < NSRC; k++) begin
         match[k] = fwd_we[k] && (fwd_addr[k*AW +: AW] == src_addr) &&
                    (src_addr != '0);
      end
   end

   // Walk from the oldest stage to the youngest so the lowest matching
   // index is the last assignment and therefore wins. Only that producer's
   // ready bit decides the hazard; an older ready copy is stale.
   always_comb begin
      any_match = 1'b0;
      sel_code  = '0;
      sel_data  = rf_data;
      sel_rdy   = 1'b1;
      for (int k = NSRC - 1; k >= 0; k--) begin
         if (match[k]) begin
            any_match = 1'b1;
            sel_code  = SELW'(k + 1);
            sel_data  = fwd_data[k*DW +: DW];
            sel_rdy   = fwd_rdy[k];
         end
      end
   end

   // Not gated by stall/flush: the pipeline controller folds it into the
   // upstream stall itself.
   assign hazard  = in_valid && any_match && !sel_rdy;
   assign capture = in_valid && !hazard;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         fwd_count <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (!stall) begin
         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= sel_code;
            if (any_match && (fwd_count != 16'hFFFF)) begin
               fwd_count <= fwd_count + 16'd1;
            end
         end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_operand_fwd_mux.sv
module tb_operand_fwd_mux;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NSRC = 3;
   localparam int SELW = $clog2(NSRC + 1);

   logic                clk = 1'b0;
   logic                reset, stall, flush, in_valid;
   logic [AW-1:0]       src_addr;
   logic [DW-1:0]       rf_data;
   logic [AW-1:0]       a0, a1, a2;
   logic [DW-1:0]       d0, d1, d2;
   logic [NSRC-1:0]     fwd_we, fwd_rdy;
   logic                hazard, out_valid;
   logic [DW-1:0]       out_data;
   logic [SELW-1:0]     out_sel;
   logic [15:0]         fwd_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   operand_fwd_mux #(.DW(DW), .AW(AW), .NSRC(NSRC)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (in_valid),
      .src_addr  (src_addr),
      .rf_data   (rf_data),
      .fwd_addr  ({a2, a1, a0}),
      .fwd_we    (fwd_we),
      .fwd_rdy   (fwd_rdy),
      .fwd_data  ({d2, d1, d0}),
      .hazard    (hazard),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .fwd_count (fwd_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [SELW-1:0] s, input logic [15:0] c);
      chk({tag, ".valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".data"},  64'(out_data),  64'(d));
      chk({tag, ".sel"},   64'(out_sel),   64'(s));
      chk({tag, ".count"}, 64'(fwd_count), 64'(c));
   endtask

   initial begin
      // reset with random inputs
      reset = 1'b1; stall = 1'($urandom); flush = 1'($urandom);
      in_valid = 1'($urandom); src_addr = AW'($urandom); rf_data = $urandom;
      a0 = AW'($urandom); a1 = AW'($urandom); a2 = AW'($urandom);
      d0 = $urandom; d1 = $urandom; d2 = $urandom;
      fwd_we = NSRC'($urandom); fwd_rdy = NSRC'($urandom);
      tick(); tick();
      chk_out("reset", 1'b0, 32'h0, 2'd0, 16'd0);

      // no match: register file
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b1; src_addr = 5'd5; rf_data = 32'h1111;
      fwd_we = 3'b000; fwd_rdy = 3'b111;
      a0 = 5'd5; a1 = 5'd5; a2 = 5'd5;
      #1 chk("nomatch.hazard", 64'(hazard), 64'd0);
      tick();
      chk_out("nomatch", 1'b1, 32'h1111, 2'd0, 16'd0);

      // priority: stages 0 and 2 both write r8
      src_addr = 5'd8; a0 = 5'd8; a1 = 5'd3; a2 = 5'd8;
      d0 = 32'hA0; d1 = 32'hB1; d2 = 32'hC2;
      fwd_we = 3'b101; fwd_rdy = 3'b111; rf_data = 32'h2222;
      tick();
      chk_out("prio", 1'b1, 32'hA0, 2'd1, 16'd1);

      // index 0 never forwards, even if a stage claims to write r0
      src_addr = 5'd0; a1 = 5'd0; fwd_we = 3'b111;
      tick();
      chk_out("r0", 1'b1, 32'h2222, 2'd0, 16'd1);

      // only stage 1 matches
      src_addr = 5'd3; a1 = 5'd3;
      tick();
      chk_out("stage1", 1'b1, 32'hB1, 2'd2, 16'd2);

      // only the oldest stage matches
      src_addr = 5'd8; a0 = 5'd7; d2 = 32'hC3;
      tick();
      chk_out("stage2", 1'b1, 32'hC3, 2'd3, 16'd3);

      // hazard: young unready match masks older ready one
      src_addr = 5'd9; a0 = 5'd9; a1 = 5'd9; a2 = 5'd1;
      d0 = 32'hA9; d1 = 32'hB9; fwd_we = 3'b011; fwd_rdy = 3'b110;
      #1 chk("haz.hazard", 64'(hazard), 64'd1);
      in_valid = 1'b0;
      #1 chk("haz.novalid", 64'(hazard), 64'd0);
      in_valid = 1'b1;
      tick();
      chk_out("haz.bubble", 1'b0, 32'h0, 2'd0, 16'd3);
      fwd_rdy = 3'b111;
      #1 chk("haz.clear", 64'(hazard), 64'd0);
      tick();
      chk_out("haz.ready", 1'b1, 32'hA9, 2'd1, 16'd4);

      // in_valid low: bubble, no count
      in_valid = 1'b0;
      tick();
      chk_out("idle", 1'b0, 32'h0, 2'd0, 16'd4);

      // capture X then stall 3 cycles with changing inputs
      in_valid = 1'b1; src_addr = 5'd5; fwd_we = 3'b000; rf_data = 32'hDEADBEEF;
      tick();
      chk_out("capx", 1'b1, 32'hDEADBEEF, 2'd0, 16'd4);
      stall = 1'b1; src_addr = 5'd9; fwd_we = 3'b011; rf_data = 32'h3333;
      tick();
      chk_out("stall1", 1'b1, 32'hDEADBEEF, 2'd0, 16'd4);
      d0 = 32'h5555;
      tick();
      chk_out("stall2", 1'b1, 32'hDEADBEEF, 2'd0, 16'd4);
      fwd_rdy = 3'b110;
      #1 chk("stall.hazard", 64'(hazard), 64'd1);
      tick();
      chk_out("stall3", 1'b1, 32'hDEADBEEF, 2'd0, 16'd4);

      // flush beats stall
      fwd_rdy = 3'b111; flush = 1'b1;
      tick();
      chk_out("flush", 1'b0, 32'h0, 2'd0, 16'd4);

      // release: current inputs captured
      flush = 1'b0; stall = 1'b0; d1 = 32'h6666; a0 = 5'd2;
      tick();
      chk_out("release", 1'b1, 32'h6666, 2'd2, 16'd5);

      // reset during stall
      stall = 1'b1; reset = 1'b1;
      tick();
      chk_out("rststall", 1'b0, 32'h0, 2'd0, 16'd0);

      // saturation: continuous forwarded captures from stage 1
      reset = 1'b0; stall = 1'b0;
      for (int i = 0; i < 65534; i++) tick();
      chk_out("sat.fffe", 1'b1, 32'h6666, 2'd2, 16'hFFFE);
      tick();
      chk("sat.ffff", 64'(fwd_count), 64'hFFFF);
      tick(); tick();
      chk("sat.hold", 64'(fwd_count), 64'hFFFF);
      reset = 1'b1;
      tick();
      chk_out("sat.reset", 1'b0, 32'h0, 2'd0, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
